// File: rtl/adat_rx_adat_tx_if.sv
// adat_rx_adat_tx_if: sample-set handshake, enable and ADAT line outputs of the transmitter.
interface adat_rx_adat_tx_if;
  logic [7:0][23:0] channels;
  logic [3:0] user;
  logic smux;
  logic valid;
  logic ready;
  logic en;
  logic adat;
  logic bit_tick;
  logic frame_start;
  logic underrun;
  modport master (output channels, user, smux, valid, en, input ready, adat, bit_tick, frame_start, underrun);
  modport slave (input channels, user, smux, valid, en, output ready, adat, bit_tick, frame_start, underrun);
endinterface

// File: rtl/adat_rx_adat_tx.sv
// adat_rx_adat_tx: ADAT optical transmitter, 8x24-bit sample sets serialized as 256-bit NRZI frames.
module adat_rx_adat_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BASE_RATE = 48000,
  parameter int ACC_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  adat_rx_adat_tx_if.slave bus
);
  localparam logic [63:0] INC64 = (((64'd1 << ACC_WIDTH) * 64'd512 * 64'(BASE_RATE)) + 64'(CLK_FREQ)) / (64'd2 * 64'(CLK_FREQ));
  localparam logic [ACC_WIDTH-1:0] INC = INC64[ACC_WIDTH-1:0];
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0] state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0] sum;
  logic tick, boundary;
  logic [7:0] bit_idx;
  logic [7:0][23:0] hold_ch, sh_ch;
  logic [3:0] hold_user, sh_user, user_tx;
  logic hold_smux, sh_smux, hold_full;
  logic [255:0] frame;
  assign sum = {1'b0, acc} + {1'b0, INC};
  assign tick = sum[ACC_WIDTH];
  assign boundary = tick && state == RUN && bit_idx == 8'd0;
  assign user_tx = sh_smux ? (sh_user | 4'b0100) : sh_user;
  assign bus.ready = !hold_full;
  // Whole frame laid out from the shadow so the serializer is a plain bit select
  assign frame[9:0] = '0;
  assign frame[10] = 1'b1;
  assign frame[255] = 1'b1;
  for (genvar j = 0; j < 4; j++) begin : usr
    assign frame[11+j] = user_tx[3-j];
  end
  for (genvar g = 0; g < 48; g++) begin : grp
    assign frame[15+5*g] = 1'b1;
    for (genvar b = 0; b < 4; b++) begin : nib
      assign frame[16+5*g+b] = sh_ch[g/6][23-4*(g%6)-b];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      bit_idx <= '0;
      hold_ch <= '0;
      hold_user <= '0;
      hold_smux <= 1'b0;
      hold_full <= 1'b0;
      sh_ch <= '0;
      sh_user <= '0;
      sh_smux <= 1'b0;
      bus.adat <= 1'b0;
      bus.bit_tick <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      acc <= sum[ACC_WIDTH-1:0];
      bus.bit_tick <= tick;
      bus.frame_start <= boundary && bus.en;
      bus.underrun <= boundary && bus.en && !hold_full;
      if (bus.valid && !hold_full) begin
        hold_ch <= bus.channels;
        hold_user <= bus.user;
        hold_smux <= bus.smux;
        hold_full <= 1'b1;
      end
      if (tick) begin
        if (state == IDLE) state <= bus.en ? RUN : IDLE;
        else if (bit_idx == 8'd0 && !bus.en) state <= IDLE;
        else begin
          bus.adat <= bus.adat ^ frame[bit_idx];
          bit_idx <= bit_idx + 8'd1;
          if (bit_idx == 8'd0 && hold_full) begin
            sh_ch <= hold_ch;
            sh_user <= hold_user;
            sh_smux <= hold_smux;
            hold_full <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_adat_rx_adat_tx.sv
// tb_adat_rx_adat_tx: decodes the NRZI line back into frames and checks them against a frame-level model.
module tb_adat_rx_adat_tx;
  localparam int CLK_FREQ = 25_000_000;
  localparam int BASE_RATE = 48000;
  localparam int FR_LO = CLK_FREQ / BASE_RATE;
  localparam int BIT_LO = CLK_FREQ / (256 * BASE_RATE);
  typedef struct {
    logic [7:0][23:0] ch;
    logic [3:0] user;
    logic und;
    logic framing;
    int start;
  } frame_t;
  typedef struct {
    logic [7:0][23:0] ch;
    logic [3:0] user;
    int at;
  } set_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  adat_rx_adat_tx_if bus();
  adat_rx_adat_tx #(.CLK_FREQ(CLK_FREQ), .BASE_RATE(BASE_RATE), .ACC_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  frame_t exp_q[$], got_q[$];
  set_t pend[$];
  set_t cur;
  int cyc = 0, tests = 0, fails = 0, nframes = 0, stray_und = 0, tick_bad = 0, last_tick = -1, idx = 0, got_start = 0;
  logic [255:0] bits;
  logic collecting = 1'b0, prev_adat = 1'b0, got_und = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  // Line monitor plus reference model: a set accepted at edge P rides the first boundary edge B with P < B
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      cur.ch = '0;
      cur.user = '0;
      cur.at = 0;
      collecting = 1'b0;
      last_tick = -1;
    end else begin
      if (bus.valid && bus.ready) begin
        set_t s;
        s.ch = bus.channels;
        s.user = {bus.user[3], bus.user[2] | bus.smux, bus.user[1:0]};
        s.at = cyc + 1;
        pend.push_back(s);
      end
      if (bus.underrun && !bus.frame_start) stray_und++;
      if (bus.bit_tick) begin
        if (last_tick >= 0 && (cyc - last_tick < BIT_LO || cyc - last_tick > BIT_LO + 1)) tick_bad++;
        last_tick = cyc;
        if (bus.frame_start) begin
          frame_t e;
          if (pend.size() > 0 && pend[0].at < cyc) begin
            cur = pend.pop_front();
            e.und = 1'b0;
          end else e.und = 1'b1;
          e.ch = cur.ch;
          e.user = cur.user;
          e.framing = 1'b1;
          e.start = cyc;
          exp_q.push_back(e);
          collecting = 1'b1;
          idx = 0;
          got_und = bus.underrun;
          got_start = cyc;
        end
        if (collecting) begin
          bits[idx] = bus.adat ^ prev_adat;
          idx++;
          if (idx == 256) begin
            frame_t g;
            g.framing = bits[9:0] == 10'd0 && bits[10] && bits[255];
            g.user = {bits[11], bits[12], bits[13], bits[14]};
            g.ch = '0;
            for (int k = 0; k < 48; k++) begin
              if (!bits[15+5*k]) g.framing = 1'b0;
              g.ch[k/6] = g.ch[k/6] | (24'({bits[16+5*k], bits[17+5*k], bits[18+5*k], bits[19+5*k]}) << (20 - 4 * (k % 6)));
            end
            g.und = got_und;
            g.start = got_start;
            got_q.push_back(g);
            nframes++;
            collecting = 1'b0;
          end
        end
      end
    end
    prev_adat = bus.adat;
  end
  function automatic bit frame_ok(frame_t g, frame_t e);
    return g.framing && g.ch === e.ch && g.user === e.user && g.und === e.und;
  endfunction
  task automatic wait_frames(input int k, output bit ok);
    int n0 = nframes;
    int t = 0;
    while (nframes < n0 + k && t < (k + 1) * (FR_LO + 2) + 50) begin
      @(negedge clk);
      t++;
    end
    ok = nframes >= n0 + k;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0][23:0] ch, input logic [3:0] u, input logic sm, output bit ok);
    int t = 0;
    bus.channels = ch;
    bus.user = u;
    bus.smux = sm;
    bus.valid = 1'b1;
    @(negedge clk);
    while (!bus.ready && t < 3 * FR_LO) begin
      @(negedge clk);
      t++;
    end
    ok = bus.ready;
    @(posedge clk);
    #1 bus.valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    tests++; if (bus.adat !== 1'b0) begin fails++; $display("FAIL reset_adat got %b want 0", bus.adat); end
    tests++; if (bus.bit_tick !== 1'b0) begin fails++; $display("FAIL reset_bit_tick got %b want 0", bus.bit_tick); end
    tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b want 0", bus.frame_start); end
    tests++; if (bus.underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", bus.underrun); end
    rst = 1'b0;
  endtask
  task automatic test_stream;
    logic [7:0][23:0] ch, fixed;
    bit ok, found;
    fixed = {24'hABCDEF, 24'h567890, 24'hF01234, 24'h9ABCDE, 24'h345678, 24'hDEF012, 24'h789ABC, 24'h123456};
    bus.en = 1'b1;
    send(fixed, 4'hA, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stream_accept got ready=0 want ready=1 within budget"); end
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 8; c++) ch[c] = 24'($urandom);
      send(ch, 4'($urandom), 1'($urandom), ok);
      tests++; if (!ok) begin fails++; $display("FAIL stream_accept_rand got ready=0 want ready=1 within budget"); end
    end
    wait_frames(3, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stream_frames got %0d frames want more", nframes); end
    found = 1'b0;
    while (got_q.size() > 0) begin
      frame_t g = got_q.pop_front();
      while (exp_q.size() > 0 && exp_q[0].start < g.start) void'(exp_q.pop_front());
      tests++;
      if (exp_q.size() == 0 || !frame_ok(g, exp_q[0])) begin
        fails++;
        $display("FAIL stream_frame@%0d got ch=%h user=%h und=%b framing=%b want ch=%h user=%h und=%b", g.start, g.ch, g.user, g.und, g.framing,
                 exp_q.size() > 0 ? exp_q[0].ch : '0, exp_q.size() > 0 ? exp_q[0].user : 4'h0, exp_q.size() > 0 ? exp_q[0].und : 1'b0);
      end
      if (g.ch === fixed && g.user === 4'hA && !g.und) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL stream_fixed_set got absent want one frame ch=%h user=a", fixed); end
  endtask
  task automatic test_spacing;
    int first = -1, prev = -1, n = 0, t = 0;
    while (n < 25 && t < 26 * (FR_LO + 2)) begin
      @(negedge clk);
      t++;
      if (bus.frame_start) begin
        if (prev >= 0) begin
          tests++;
          if (cyc - prev != FR_LO && cyc - prev != FR_LO + 1) begin fails++; $display("FAIL frame_spacing got %0d want %0d or %0d", cyc - prev, FR_LO, FR_LO + 1); end
        end else first = cyc;
        prev = cyc;
        n++;
      end
    end
    tests++;
    if (n != 25 || prev - first < 24 * CLK_FREQ / BASE_RATE - 1 || prev - first > 24 * CLK_FREQ / BASE_RATE + 1) begin
      fails++; $display("FAIL frame_total got %0d over %0d starts want %0d+-1 over 25", prev - first, n, 24 * CLK_FREQ / BASE_RATE);
    end
    tests++; if (tick_bad != 0) begin fails++; $display("FAIL tick_spacing got %0d bad gaps want 0", tick_bad); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_underrun;
    logic [7:0][23:0] ch;
    bit ok;
    int n = 0;
    for (int c = 0; c < 8; c++) ch[c] = 24'($urandom);
    send(ch, 4'h5, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL underrun_accept got ready=0 want ready=1 within budget"); end
    wait_frames(2, ok);
    got_q.delete();
    wait_frames(3, ok);
    while (got_q.size() > 0) begin
      frame_t g = got_q.pop_front();
      n++;
      tests++;
      if (g.und !== 1'b1 || g.ch !== ch || g.user !== 4'h5 || !g.framing) begin
        fails++; $display("FAIL underrun_repeat got und=%b ch=%h user=%h want und=1 ch=%h user=5", g.und, g.ch, g.user, ch);
      end
    end
    tests++; if (n != 3) begin fails++; $display("FAIL underrun_frames got %0d want 3", n); end
    tests++; if (stray_und != 0) begin fails++; $display("FAIL underrun_stray got %0d want 0", stray_und); end
  endtask
  task automatic test_back_to_back;
    logic [7:0][23:0] ch;
    int k = 0, t = 0, expv = 0;
    bit ok;
    got_q.delete();
    for (int c = 0; c < 7; c++) ch[c] = 24'(c * 4096);
    ch[7] = {12'hB2B, 12'd0};
    bus.channels = ch;
    bus.user = 4'h3;
    bus.smux = 1'b0;
    bus.valid = 1'b1;
    while (k < 6 && t < 8 * (FR_LO + 2)) begin
      @(negedge clk);
      t++;
      if (bus.ready) begin
        tests++;
        if (k > 0 && bus.frame_start !== 1'b1) begin fails++; $display("FAIL b2b_accept_timing got frame_start=%b want 1 at accept %0d", bus.frame_start, k); end
        k++;
        @(posedge clk);
        #1;
        for (int c = 0; c < 7; c++) ch[c] = 24'(c * 4096 + k);
        ch[7] = {12'hB2B, 12'(k)};
        bus.channels = ch;
      end
    end
    bus.valid = 1'b0;
    tests++; if (k != 6) begin fails++; $display("FAIL b2b_accepts got %0d want 6", k); end
    wait_frames(3, ok);
    while (got_q.size() > 0) begin
      frame_t g = got_q.pop_front();
      while (exp_q.size() > 0 && exp_q[0].start < g.start) void'(exp_q.pop_front());
      tests++;
      if (exp_q.size() == 0 || !frame_ok(g, exp_q[0])) begin fails++; $display("FAIL b2b_frame@%0d got ch7=%h und=%b want model match", g.start, g.ch[7], g.und); end
      if (g.ch[7][23:12] == 12'hB2B && !g.und) begin
        tests++;
        if (g.ch[7][11:0] !== 12'(expv)) begin fails++; $display("FAIL b2b_sequence got %0d want %0d", g.ch[7][11:0], expv); end
        expv++;
      end
    end
    tests++; if (expv != 6) begin fails++; $display("FAIL b2b_count got %0d fresh frames want 6", expv); end
  endtask
  task automatic test_smux;
    logic [7:0][23:0] ch;
    bit ok;
    ch = {24'hDD1111, 24'hDD0000, 24'hCC1111, 24'hCC0000, 24'hBB1111, 24'hBB0000, 24'hAA1111, 24'hAA0000};
    send(ch, 4'h0, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL smux_accept got ready=0 want ready=1 within budget"); end
    wait_frames(2, ok);
    got_q.delete();
    wait_frames(1, ok);
    tests++;
    if (got_q.size() == 0 || got_q[$].user !== 4'b0100) begin fails++; $display("FAIL smux_user got %h want 4", got_q.size() > 0 ? got_q[$].user : 4'hx); end
    tests++;
    if (got_q.size() == 0 || got_q[$].ch !== ch || !got_q[$].framing) begin fails++; $display("FAIL smux_channels got %h want %h", got_q.size() > 0 ? got_q[$].ch : '0, ch); end
  endtask
  task automatic test_en_reset;
    bit ok;
    int t = 0, changes = 0, starts = 0, n0;
    logic level;
    while (!(collecting && idx >= 100) && t < 2 * FR_LO) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 bus.en = 1'b0;
    n0 = nframes;
    wait_frames(1, ok);
    tests++;
    if (nframes != n0 + 1 || !got_q[$].framing) begin fails++; $display("FAIL en_drop_complete got %0d frames want 1 complete frame", nframes - n0); end
    @(negedge clk);
    level = bus.adat;
    for (int i = 0; i < 3 * FR_LO; i++) begin
      @(negedge clk);
      if (bus.adat !== level) changes++;
      if (bus.frame_start) starts++;
    end
    tests++; if (changes != 0) begin fails++; $display("FAIL en_idle_line got %0d changes want 0", changes); end
    tests++; if (starts != 0) begin fails++; $display("FAIL en_idle_frames got %0d frame starts want 0", starts); end
    @(posedge clk);
    #1 bus.en = 1'b1;
    wait_frames(2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL en_resume got no frames want 2"); end
    t = 0;
    while (!(collecting && idx >= 50) && t < 2 * FR_LO) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++; if (bus.adat !== 1'b0) begin fails++; $display("FAIL rst_async_adat got %b want 0", bus.adat); end
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL rst_async_ready got %b want 1", bus.ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    wait_frames(1, ok);
    tests++;
    if (got_q.size() == 0 || got_q[0].ch !== '0 || got_q[0].user !== 4'h0 || got_q[0].und !== 1'b1 || !got_q[0].framing) begin
      fails++; $display("FAIL rst_first_frame got ch=%h und=%b want zero data und=1", got_q.size() > 0 ? got_q[0].ch : '1, got_q.size() > 0 ? got_q[0].und : 1'b0);
    end
  endtask
  initial begin
    bus.channels = '0;
    bus.user = '0;
    bus.smux = 1'b0;
    bus.valid = 1'b0;
    bus.en = 1'b0;
    test_reset();
    test_stream();
    test_spacing();
    test_underrun();
    test_back_to_back();
    test_smux();
    test_en_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
